// File: rtl/wb_stage.sv
// Writeback stage: MEM/WB holding register, load extension, regfile write port.
// Optional WB_BYPASS_EN adds a same-cycle write-to-read bypass for decode.
module wb_stage #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_rd,
  input  logic             in_regwrite,
  input  logic [1:0]       in_wb_sel,
  input  logic [31:0]      in_alu_result,
  input  logic [31:0]      in_pc_plus4,
  input  logic [2:0]       in_funct3,
  input  logic [31:0]      dmem_rdata,
  input  logic             dmem_rvalid,
`ifdef WB_BYPASS_EN
  input  logic [4:0]       Raddr1,
  input  logic [4:0]       Raddr2,
  input  logic [31:0]      rf_rd1,
  input  logic [31:0]      rf_rd2,
  output logic [31:0]      byp_rd1,
  output logic [31:0]      byp_rd2,
`endif
  output logic             writeEn,
  output logic [4:0]       Waddr,
  output logic [31:0]      writeData,
  output logic             retire,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    LOAD_WAIT
  } state_t;

  state_t state, state_nxt;

  logic        valid_q;
  logic [4:0]  rd_q;
  logic        regw_q;
  logic [1:0]  sel_q;
  logic [31:0] alu_q;
  logic [31:0] pc4_q;
  logic [2:0]  f3_q;

  logic [4:0]  waddr_q;
  logic [31:0] wdata_q;

  logic        accept;
  logic        ret_now;
  logic        we;
  logic [31:0] wdata;
  logic [7:0]  lb;
  logic [15:0] lh;
  logic [31:0] ldata;

  // Next state and handshake; in_ready never looks at in_valid
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b1;
    ret_now   = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
      end
      WRITE: begin
        in_ready = 1'b1;
        ret_now  = valid_q;
      end
      LOAD_WAIT: begin
        in_ready = dmem_rvalid;
        ret_now  = valid_q && dmem_rvalid;
      end
      default: begin
        in_ready = 1'b1;
      end
    endcase
    accept = in_valid && in_ready;
    unique case (1'b1)
      accept:
        state_nxt = (in_wb_sel == 2'b01) ? LOAD_WAIT : WRITE;
      (state == LOAD_WAIT) && !dmem_rvalid:
        state_nxt = LOAD_WAIT;
      default:
        state_nxt = IDLE;
    endcase
  end

  // Load byte/half selection and extension
  always_comb begin
    lb = 8'h0;
    unique case (alu_q[1:0])
      2'd0: lb = dmem_rdata[7:0];
      2'd1: lb = dmem_rdata[15:8];
      2'd2: lb = dmem_rdata[23:16];
      2'd3: lb = dmem_rdata[31:24];
      default: lb = 8'h0;
    endcase
    lh = alu_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    unique case (1'b1)
      f3_q == 3'b000: ldata = {{24{lb[7]}}, lb};
      f3_q == 3'b100: ldata = {24'h0, lb};
      f3_q == 3'b001: ldata = {{16{lh[15]}}, lh};
      f3_q == 3'b101: ldata = {16'h0, lh};
      default:        ldata = dmem_rdata;
    endcase
  end

  // Writeback mux and write port; address/data hold when not writing
  always_comb begin
    unique case (sel_q)
      2'b00:   wdata = alu_q;
      2'b01:   wdata = ldata;
      2'b10:   wdata = pc4_q;
      default: wdata = 32'h0;
    endcase
    we        = ret_now && regw_q && (rd_q != 5'd0);
    writeEn   = we;
    Waddr     = we ? rd_q : waddr_q;
    writeData = we ? wdata : wdata_q;
    retire    = ret_now;
  end

`ifdef WB_BYPASS_EN
  // Forward the in-flight write to decode's read ports
  always_comb begin
    byp_rd1 = rf_rd1;
    byp_rd2 = rf_rd2;
    if (writeEn && (Waddr == Raddr1) && (Raddr1 != 5'd0))
      byp_rd1 = writeData;
    if (writeEn && (Waddr == Raddr2) && (Raddr2 != 5'd0))
      byp_rd2 = writeData;
  end
`endif

  // State, holding register, last-write latch and retire counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      valid_q <= 1'b0;
      rd_q    <= '0;
      regw_q  <= 1'b0;
      sel_q   <= '0;
      alu_q   <= '0;
      pc4_q   <= '0;
      f3_q    <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      instret <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        valid_q <= 1'b1;
        rd_q    <= in_rd;
        regw_q  <= in_regwrite;
        sel_q   <= in_wb_sel;
        alu_q   <= in_alu_result;
        pc4_q   <= in_pc_plus4;
        f3_q    <= in_funct3;
      end else if (ret_now) begin
        valid_q <= 1'b0;
      end
      if (we) begin
        waddr_q <= rd_q;
        wdata_q <= wdata;
      end
      if (ret_now)
        instret <= instret + 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage.
// Inputs change 1ns after rising edges; outputs are checked on falling edges.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic        in_regwrite;
  logic [1:0]  in_wb_sel;
  logic [31:0] in_alu_result;
  logic [31:0] in_pc_plus4;
  logic [2:0]  in_funct3;
  logic [31:0] dmem_rdata;
  logic        dmem_rvalid;
  logic        writeEn;
  logic [4:0]  Waddr;
  logic [31:0] writeData;
  logic        retire;
  logic [31:0] instret;
`ifdef WB_BYPASS_EN
  logic [4:0]  Raddr1, Raddr2;
  logic [31:0] rf_rd1, rf_rd2, byp_rd1, byp_rd2;
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] base;

  always #5 clk = ~clk;

  wb_stage #(.CNT_W(32)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_rd(in_rd),
    .in_regwrite(in_regwrite),
    .in_wb_sel(in_wb_sel),
    .in_alu_result(in_alu_result),
    .in_pc_plus4(in_pc_plus4),
    .in_funct3(in_funct3),
    .dmem_rdata(dmem_rdata),
    .dmem_rvalid(dmem_rvalid),
`ifdef WB_BYPASS_EN
    .Raddr1(Raddr1),
    .Raddr2(Raddr2),
    .rf_rd1(rf_rd1),
    .rf_rd2(rf_rd2),
    .byp_rd1(byp_rd1),
    .byp_rd2(byp_rd2),
`endif
    .writeEn(writeEn),
    .Waddr(Waddr),
    .writeData(writeData),
    .retire(retire),
    .instret(instret)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic drive(input logic [4:0] rd, input logic rw,
                       input logic [1:0] sel, input logic [31:0] alu,
                       input logic [31:0] pc4, input logic [2:0] f3);
    in_valid      = 1'b1;
    in_rd         = rd;
    in_regwrite   = rw;
    in_wb_sel     = sel;
    in_alu_result = alu;
    in_pc_plus4   = pc4;
    in_funct3     = f3;
  endtask

  // Load with two empty wait cycles, data on the third
  task automatic load_late(input string tag, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] rdata,
                           input logic [31:0] exp);
    step();
    drive(5'd6, 1'b1, 2'b01, a, 32'h0, f3);
    step();
    in_valid = 1'b0;
    at_neg();
    chk({tag, "_rdy_w1"}, in_ready, 0);
    chk({tag, "_we_w1"}, writeEn, 0);
    step();
    at_neg();
    chk({tag, "_rdy_w2"}, in_ready, 0);
    step();
    dmem_rvalid = 1'b1;
    dmem_rdata  = rdata;
    at_neg();
    chk({tag, "_rdy_w3"}, in_ready, 1);
    chk({tag, "_we"}, writeEn, 1);
    chk({tag, "_data"}, writeData, exp);
    step();
    dmem_rvalid = 1'b0;
    dmem_rdata  = 32'h0;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_rd = '0;
    in_regwrite = 1'b0;
    in_wb_sel = '0;
    in_alu_result = '0;
    in_pc_plus4 = '0;
    in_funct3 = '0;
    dmem_rdata = '0;
    dmem_rvalid = 1'b0;
`ifdef WB_BYPASS_EN
    Raddr1 = '0;
    Raddr2 = '0;
    rf_rd1 = '0;
    rf_rd2 = '0;
`endif
    step();
    at_neg();
    chk("rst_we", writeEn, 0);
    chk("rst_waddr", Waddr, 0);
    chk("rst_wdata", writeData, 0);
    chk("rst_retire", retire, 0);
    chk("rst_instret", instret, 0);
    chk("rst_ready", in_ready, 1);
    rst = 1'b0;

    // ALU op
    step();
    drive(5'd5, 1'b1, 2'b00, 32'h1234_5678, 32'h0, 3'b000);
    step();
    in_valid = 1'b0;
    at_neg();
    chk("alu_we", writeEn, 1);
    chk("alu_waddr", Waddr, 5);
    chk("alu_wdata", writeData, 32'h1234_5678);
    chk("alu_retire", retire, 1);
    step();
    at_neg();
    chk("alu_instret", instret, 1);
    chk("alu_retire_end", retire, 0);
    chk("alu_hold_waddr", Waddr, 5);
    chk("alu_hold_wdata", writeData, 32'h1234_5678);

    // Loads with late data
    load_late("lb", 3'b000, 32'h1002, 32'h0080_0000, 32'hFFFF_FF80);
    load_late("lbu", 3'b100, 32'h1002, 32'h0080_0000, 32'h0000_0080);
    load_late("lh", 3'b001, 32'h1002, 32'h8001_0000, 32'hFFFF_8001);
    load_late("lhu", 3'b101, 32'h1001, 32'h8001_F00D, 32'h0000_F00D);
    load_late("lw", 3'b010, 32'h1003, 32'hCAFE_0001, 32'hCAFE_0001);
    load_late("lb3", 3'b000, 32'h1003, 32'h7F00_0000, 32'h0000_007F);
    at_neg();
    chk("load_instret", instret, 7);

    // x0 write and regwrite=0 both suppress the write but still retire
    base = instret;
    drive(5'd0, 1'b1, 2'b00, 32'h1111_1111, 32'h0, 3'b000);
    step();
    drive(5'd7, 1'b0, 2'b00, 32'h2222_2222, 32'h0, 3'b000);
    at_neg();
    chk("x0_we", writeEn, 0);
    chk("x0_retire", retire, 1);
    step();
    in_valid = 1'b0;
    at_neg();
    chk("nrw_we", writeEn, 0);
    chk("nrw_retire", retire, 1);
    chk("nrw_hold_waddr", Waddr, 6);
    step();
    at_neg();
    chk("nowr_instret", instret, base + 2);

    // Back-to-back: ALU, JAL, load (data in first wait cycle), ALU
    base = instret;
    step();
    drive(5'd1, 1'b1, 2'b00, 32'h0000_000A, 32'h0, 3'b000);
    step();
    drive(5'd2, 1'b1, 2'b10, 32'h0, 32'h0000_0104, 3'b000);
    at_neg();
    chk("b2b_ready0", in_ready, 1);
    chk("b2b_ret0", retire, 1);
    chk("b2b_data0", writeData, 32'h0000_000A);
    step();
    drive(5'd3, 1'b1, 2'b01, 32'h2000, 32'h0, 3'b010);
    at_neg();
    chk("b2b_ready1", in_ready, 1);
    chk("b2b_ret1", retire, 1);
    chk("b2b_data1", writeData, 32'h0000_0104);
    step();
    drive(5'd4, 1'b1, 2'b00, 32'h0000_000B, 32'h0, 3'b000);
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'hCAFE_BABE;
    at_neg();
    chk("b2b_ready2", in_ready, 1);
    chk("b2b_ret2", retire, 1);
    chk("b2b_data2", writeData, 32'hCAFE_BABE);
    chk("b2b_addr2", Waddr, 3);
    step();
    in_valid = 1'b0;
    dmem_rvalid = 1'b0;
    at_neg();
    chk("b2b_ret3", retire, 1);
    chk("b2b_data3", writeData, 32'h0000_000B);
    step();
    at_neg();
    chk("b2b_instret", instret, base + 4);
    chk("b2b_idle", retire, 0);

`ifdef WB_BYPASS_EN
    step();
    drive(5'd3, 1'b1, 2'b00, 32'hDEAD_BEEF, 32'h0, 3'b000);
    step();
    in_valid = 1'b0;
    Raddr1 = 5'd3;
    rf_rd1 = 32'h0;
    Raddr2 = 5'd0;
    rf_rd2 = 32'h0000_0055;
    at_neg();
    chk("byp_rd1", byp_rd1, 32'hDEAD_BEEF);
    chk("byp_rd2", byp_rd2, 32'h0000_0055);
    step();
    at_neg();
    chk("byp_rd1_off", byp_rd1, 32'h0);
`endif

    // Reset in the middle of a load
    step();
    drive(5'd9, 1'b1, 2'b01, 32'h3000, 32'h0, 3'b010);
    step();
    in_valid = 1'b0;
    at_neg();
    chk("mid_wait", in_ready, 0);
    rst = 1'b1;
    #2;
    chk("mid_rst_instret", instret, 0);
    chk("mid_rst_waddr", Waddr, 0);
    chk("mid_rst_we", writeEn, 0);
    step();
    rst = 1'b0;
    step();
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h5555_5555;
    at_neg();
    chk("post_rst_we", writeEn, 0);
    chk("post_rst_retire", retire, 0);
    chk("post_rst_ready", in_ready, 1);
    step();
    dmem_rvalid = 1'b0;
    at_neg();
    chk("post_rst_instret", instret, 0);
    chk("post_rst_wdata", writeData, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
Writeback stage of the 5-stage pipeline. It is the writer side of the register file: it captures the MEM/WB pipeline register and waits for delayed load data. It extracts and extends load bytes and halfwords, then drives the regfile write port (writeEn/Waddr/writeData). It also counts retired instructions and exerts backpressure on MEM while a load is outstanding.

Parameters:
CNT_W, 32, width of retired-instruction counter instret (wraps modulo 2^CNT_W)

Ports:
clk  input  1  pipeline clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  MEM stage presents an instruction
in_ready  output  1  wb_stage accepts the instruction this cycle
in_rd  input  5  destination register
in_regwrite  input  1  instruction writes rd
in_wb_sel  input  2  00 ALU result, 01 load data, 10 PC+4, 11 reserved (writes 0)
in_alu_result  input  32  ALU result / load effective address
in_pc_plus4  input  32  link value for JAL/JALR
in_funct3  input  3  load size/sign encoding
dmem_rdata  input  32  aligned word from data memory
dmem_rvalid  input  1  dmem_rdata valid this cycle
writeEn  output  1  regfile write enable
Waddr  output  5  regfile write address
writeData  output  32  regfile write data
retire  output  1  one-cycle pulse per retired instruction
instret  output  CNT_W  retired-instruction count

Behaviour:
- Holding register: valid, rd, regwrite, wb_sel, alu_result, pc_plus4, funct3. It loads on the rising edge when in_valid && in_ready.
- States: IDLE, WRITE, LOAD_WAIT.
- IDLE: no instruction held. in_ready=1. On accept, go to LOAD_WAIT if in_wb_sel==01, else WRITE.
- WRITE: held instruction retires this cycle. in_ready=1. On accept, go to WRITE or LOAD_WAIT as above; otherwise go to IDLE.
- LOAD_WAIT: in_ready=dmem_rvalid.
  - dmem_rvalid=0: stay; writeEn=0.
  - dmem_rvalid=1: retire this cycle, with the same next-state rules as WRITE.
- Retire cycle outputs:
  - writeEn = regwrite && rd!=0. x0 is never written.
  - Waddr = rd.
  - retire = 1, including when regwrite=0.
- Waddr and writeData hold their last values when writeEn=0.
- Regfile latches the write at the rising edge ending the retire cycle. Write-to-use latency is 1 cycle.
- Write data by wb_sel:
  - 00: alu_result
  - 10: pc_plus4
  - 11: 32'h0
  - 01: extended load data; byte lane from alu_result[1:0]
- Load extension by funct3:
  - 000 LB: dmem_rdata byte[a[1:0]], sign-extended.
  - 100 LBU: same byte, zero-extended.
  - 001 LH: half[a[1]], sign-extended; a[0] ignored.
  - 101 LHU: half[a[1]], zero-extended.
  - 010 LW and 011/110/111: full word; a[1:0] ignored.
- instret increments by 1 on every retire cycle and wraps to 0.
- Reset (async, any state, including mid-load):
  - state IDLE, holding valid 0, writeEn 0, Waddr 0, writeData 0, retire 0, instret 0.
  - A load outstanding at reset is discarded. A dmem_rvalid arriving after reset is ignored.
- in_ready is combinational from state and dmem_rvalid only, never from in_valid.
- Throughput: one instruction per cycle for non-loads; one per cycle for loads when dmem_rvalid arrives in the first LOAD_WAIT cycle.

Optional Feature:
WB_BYPASS_EN:
- Defined: adds inputs Raddr1[5], Raddr2[5], rf_rd1[32], rf_rd2[32] and outputs byp_rd1[32], byp_rd2[32].
- byp_rdN = writeData when writeEn && Waddr==RaddrN && RaddrN!=0; otherwise rf_rdN. Purely combinational.
- This lets decode read a value being written in the same cycle.
- Undefined: these ports do not exist; decode sees the new value one cycle after the write.

Test Plan:
- Reset, then accept ALU op rd=5, alu_result=32'h1234_5678 -> next cycle writeEn=1, Waddr=5, writeData=32'h1234_5678, retire=1, instret=1.
- Load LB funct3=000, a[1:0]=2, rvalid 3 cycles late, dmem_rdata=32'h0080_0000 -> in_ready=0 for 2 cycles; on rvalid cycle writeData=32'hFFFF_FF80. Repeat with LBU -> 32'h0000_0080. LH a=2, rdata=32'h8001_0000 -> 32'hFFFF_8001.
- rd=0 with regwrite=1, and regwrite=0 with rd=7 -> writeEn=0 both times, retire=1, instret increments by 2.
- Back-to-back: ALU, JAL (wb_sel=10, pc_plus4=32'h104), load with rvalid in first wait cycle, ALU -> four consecutive retire pulses, no in_ready deassertion.
- Assert rst during LOAD_WAIT, then pulse dmem_rvalid -> writeEn stays 0, instret=0, state IDLE.
- WB_BYPASS_EN: write rd=3 data 32'hDEAD_BEEF while Raddr1=3, rf_rd1=0 -> byp_rd1=32'hDEAD_BEEF; Raddr2=0 -> byp_rd2=rf_rd2.
